csr_mfile: RTL
==============

# csr_mfile

Machine-mode CSR register file and trap sequencer for the RV64 core. It sits directly downstream of the CSR package definitions (addresses, mcause encodings, mstatus layout) and between the execute stage and fetch. It serves CSR read/modify/write requests, records trap state on exceptions and interrupts, performs `mret`, and issues a registered PC redirect to fetch.

## Interface

**Parameters**
- `HartId`, default 0: value returned by `mhartid`.
- `MisaExt`, default 26'h100 (I only): `misa[25:0]` extension bits. `misa[63:62]` is fixed at 2'b10.

**Ports**
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `csr_valid_i` in 1: CSR request. Always accepted; there is no ready.
- `csr_addr_i` in 12: CSR address (`csr_addrs_e`).
- `csr_op_i` in 2: 00 read, 01 write, 10 set, 11 clear. The core encodes `rs1==x0` set/clear as 00.
- `csr_wdata_i` in Xlen: operand.
- `csr_rvalid_o` out 1: response valid.
- `csr_rdata_o` out Xlen: old CSR value.
- `csr_illegal_o` out 1: access fault; qualified by `csr_rvalid_o`.
- `trap_valid_i` in 1: take trap.
- `trap_cause_i` in Xlen: `csr_mcause_e` value.
- `trap_pc_i` in Xlen: faulting / interrupted PC.
- `trap_tval_i` in Xlen: mtval value.
- `mret_i` in 1: execute `mret`.
- `irq_msip_i`, `irq_mtip_i`, `irq_meip_i` in 1 each: interrupt lines, level-sensitive.
- `irq_pending_o` out 1: enabled interrupt pending.
- `irq_cause_o` out Xlen: highest-priority pending interrupt cause.
- `redirect_valid_o` out 1: one-cycle redirect pulse.
- `redirect_pc_o` out Xlen: target PC.

## Operation

**Implemented CSRs**
- `mhartid`: read-only.
- `misa`: WARL; writes ignored.
- `mstatus`: only `mie`, `mpie` and `mpp` are stored. `mpp` always reads 2'b11. All other fields read 0.
- `mstatush`: reads 0; writes ignored.
- `mie`: bits 3, 7 and 11 are writable; all other bits read 0.
- `mtvec`: see Configuration.
- `mscratch`: full width.
- `mepc`: bits [1:0] read 0.
- `mcause`: full width.
- `mtval`: full width.
- `mip`: bits 3, 7 and 11 reflect the `irq_*` inputs; read-only.

**CSR access rules**
- Op 01 stores `wdata`. Op 10 stores `old | wdata`. Op 11 stores `old & ~wdata`. The WARL masks above are then applied.
- `csr_illegal_o` is set, and no state changes, when either:
  - the address is unimplemented, or
  - `addr[11:10]==2'b11` and op != 00.
- A write to `mip` (op != 00) is ignored and is not illegal.

**Trap entry** (on `trap_valid_i`)
- `mepc <= {trap_pc_i[63:2], 2'b00}`
- `mcause <= trap_cause_i`
- `mtval <= trap_tval_i`
- `mpie <= mie`
- `mie <= 0`
- Redirect to the trap vector.

**mret**
- `mie <= mpie`
- `mpie <= 1`
- Redirect to `mepc`.

**Same-cycle priority:** trap > mret > CSR. A lower-priority event is squashed: no state change, and a squashed CSR request gets `csr_rvalid_o=0`.

**Interrupts**
- pending = `mip & mie` and `mstatus.mie`.
- Priority order: MEI (11) > MSI (3) > MTI (7).
- `irq_cause_o = {1'b1, 63'(code)}`; it is 0 when nothing is pending.
- The core raises `trap_valid_i` with `irq_cause_o` to take the interrupt.

## Timing

- **CSR response:** all outputs are registered, 1-cycle latency. A request at edge N produces `csr_rvalid_o`, `csr_rdata_o` and `csr_illegal_o` valid for cycle N+1, as a single-cycle pulse.
- **Write visibility:** the write commits at edge N. A back-to-back read at N+1 returns the new value.
- **Redirect:** a trap or mret at edge N produces `redirect_valid_o=1` for exactly cycle N+1.
- **mret after write:** `redirect_pc_o` for mret is the `mepc` value after any same-edge update. No same-edge update is possible, because mret squashes the CSR request.
- **Interrupt outputs:** `irq_pending_o` and `irq_cause_o` are combinational from registered state and inputs. They drop the cycle after trap entry clears `mie`.
- **Reset values:**
  - Outputs `csr_rvalid_o`, `csr_illegal_o` and `redirect_valid_o` are 0; `csr_rdata_o` and `redirect_pc_o` are 0.
  - `mie`, `mpie`, `mie` register, `mtvec`, `mepc`, `mcause`, `mtval` and `mscratch` are 0.
- **Reset mid-operation:** a pending response or redirect is dropped.

## Configuration

Macro: `CSR_MTVEC_VECTORED_EN`.

**Defined:**
- `mtvec[1:0]` accepts 0 (direct) and 1 (vectored). Written values 2 and 3 store 0.
- For an interrupt trap in vectored mode, the target is `{mtvec[63:2],2'b00} + 4*cause[62:0]`.
- Exceptions always go to the base address.

**Undefined:**
- `mtvec[1:0]` is hardwired to 0.
- All traps go to `{mtvec[63:2],2'b00}`.

## Test plan

- **Write then read:** write 0x8000_0100 to `mtvec`, then read it back → returns 0x8000_0100. With the macro defined, writing 0x8000_0103 reads back 0x8000_0100.
- **Read-only and unimplemented:** write to `mhartid` (0xf14) → `csr_illegal_o=1`, value still `HartId`. Read 0x7c0 → illegal.
- **Trap entry:**
  - Setup: `mie=1`; trap with cause `IllegalInst`, pc 0x1002, tval 0xdead.
  - Result at N+1: `redirect_pc_o` = mtvec base; `mepc`=0x1000; `mcause`=2; `mtval`=0xdead; `mstatus.mpie`=1, `mstatus.mie`=0.
- **mret:** after the above, `mret_i` → redirect 0x1000 at N+1; `mie`=1, `mpie`=1.
- **Interrupt priority:**
  - Setup: `mstatus.mie`=1, `mie`=0x888; `irq_mtip_i`=1 and `irq_meip_i`=1.
  - Result: `irq_cause_o`={1,63'd11}. Trapping with it clears `irq_pending_o` the next cycle. With the macro defined and mtvec=0x101, redirect = 0x12c.
- **Same-cycle collision:** CSR write to `mscratch`, trap and mret in the same cycle → only the trap takes effect, `csr_rvalid_o=0`, and `mscratch` is unchanged.

Source files
------------

// File: rtl/csr_mfile.sv
// Machine-mode CSR file and trap sequencer for the RV64 core.
// Optional vectored mtvec mode: define CSR_MTVEC_VECTORED_EN.
module csr_mfile #(
  parameter logic [63:0] HartId  = 64'd0,
  parameter logic [25:0] MisaExt = 26'h100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_valid_i,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [63:0] csr_wdata_i,
  output logic        csr_rvalid_o,
  output logic [63:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_valid_i,
  input  logic [63:0] trap_cause_i,
  input  logic [63:0] trap_pc_i,
  input  logic [63:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        irq_msip_i,
  input  logic        irq_mtip_i,
  input  logic        irq_meip_i,
  output logic        irq_pending_o,
  output logic [63:0] irq_cause_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMisa     = 12'h301;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMstatush = 12'h310;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMhartid  = 12'hf14;

  logic        st_mie;
  logic        st_mpie;
  logic [2:0]  mie_q;
  logic [61:0] mtvec_base;
  logic        mtvec_mode;
  logic [63:0] mscratch;
  logic [61:0] mepc;
  logic [63:0] mcause;
  logic [63:0] mtval;

  logic [63:0] rd;
  logic [63:0] wval;
  logic        impl;
  logic        illegal;
  logic        take_mret;
  logic        take_csr;
  logic        wr_en;
  logic [2:0]  mip;
  logic [2:0]  pend;
  logic [3:0]  code;
  logic [63:0] base;
  logic [63:0] trap_tgt;
  logic [1:0]  unused_pc;

  assign unused_pc = trap_pc_i[1:0];

`ifndef CSR_MTVEC_VECTORED_EN
  assign mtvec_mode = 1'b0;
`endif

  assign mip  = {irq_meip_i, irq_mtip_i, irq_msip_i};
  assign base = {mtvec_base, 2'b00};

  always_comb begin
    rd   = '0;
    impl = 1'b1;
    case (csr_addr_i)
      AddrMstatus: begin
        rd[3]     = st_mie;
        rd[7]     = st_mpie;
        rd[12:11] = 2'b11;
      end
      AddrMisa:     rd = {2'b10, 36'd0, MisaExt};
      AddrMie:      begin
        rd[3]  = mie_q[0];
        rd[7]  = mie_q[1];
        rd[11] = mie_q[2];
      end
      AddrMtvec:    rd = {mtvec_base, 1'b0, mtvec_mode};
      AddrMstatush: rd = '0;
      AddrMscratch: rd = mscratch;
      AddrMepc:     rd = {mepc, 2'b00};
      AddrMcause:   rd = mcause;
      AddrMtval:    rd = mtval;
      AddrMip:      begin
        rd[3]  = mip[0];
        rd[7]  = mip[1];
        rd[11] = mip[2];
      end
      AddrMhartid:  rd = HartId;
      default:      impl = 1'b0;
    endcase
  end

  always_comb begin
    wval = rd;
    unique case (csr_op_i)
      2'b01:   wval = csr_wdata_i;
      2'b10:   wval = rd | csr_wdata_i;
      2'b11:   wval = rd & ~csr_wdata_i;
      default: wval = rd;
    endcase
  end

  assign illegal   = !impl
                   || (csr_addr_i[11:10] == 2'b11 && csr_op_i != 2'b00);
  assign take_mret = mret_i && !trap_valid_i;
  assign take_csr  = csr_valid_i && !trap_valid_i && !mret_i;
  assign wr_en     = take_csr && !illegal && csr_op_i != 2'b00;

  // Vectored mode only offsets interrupts; exceptions use the base.
  always_comb begin
    trap_tgt = base;
    if (mtvec_mode && trap_cause_i[63])
      trap_tgt = base + {trap_cause_i[61:0], 2'b00};
  end

  // Fixed priority: MEI > MSI > MTI.
  assign pend = mip & mie_q & {3{st_mie}};
  always_comb begin
    code = 4'd0;
    if (pend[2])      code = 4'd11;
    else if (pend[0]) code = 4'd3;
    else if (pend[1]) code = 4'd7;
  end
  assign irq_pending_o = |pend;
  assign irq_cause_o   = irq_pending_o ? {1'b1, 59'd0, code} : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_base <= '0;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
    end else if (trap_valid_i) begin
      mepc    <= trap_pc_i[63:2];
      mcause  <= trap_cause_i;
      mtval   <= trap_tval_i;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (take_mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr_i)
        AddrMstatus: begin
          st_mie  <= wval[3];
          st_mpie <= wval[7];
        end
        AddrMie:      mie_q <= {wval[11], wval[7], wval[3]};
        AddrMtvec:    mtvec_base <= wval[63:2];
        AddrMscratch: mscratch <= wval;
        AddrMepc:     mepc <= wval[63:2];
        AddrMcause:   mcause <= wval;
        AddrMtval:    mtval <= wval;
        default:      ;
      endcase
    end
  end

`ifdef CSR_MTVEC_VECTORED_EN
  // Reserved modes 2 and 3 fall back to direct.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      mtvec_mode <= 1'b0;
    else if (wr_en && csr_addr_i == AddrMtvec)
      mtvec_mode <= (wval[1:0] == 2'b01);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csr_rvalid_o     <= 1'b0;
      csr_rdata_o      <= '0;
      csr_illegal_o    <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      csr_rvalid_o     <= take_csr;
      csr_rdata_o      <= illegal ? '0 : rd;
      csr_illegal_o    <= take_csr && illegal;
      redirect_valid_o <= trap_valid_i || mret_i;
      if (trap_valid_i)
        redirect_pc_o <= trap_tgt;
      else if (mret_i)
        redirect_pc_o <= {mepc, 2'b00};
    end
  end

endmodule
